bank_read_sequencer: RTL and testbench

//  Parametrised, registered successor to the 4-bank combinational read-enable decode.

---
 rtl/bank_read_sequencer.sv | 166 ++++++++++++++++
 tb/tb_bank_read_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_read_sequencer.sv
// Valid/ready read sequencer driving a registered one-hot bank read enable, with idle
// turnaround cycles on a bank change. Optional stats counters: BANK_READ_SEQ_STATS_EN.
module bank_read_sequencer #(
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned SEL_W       = $clog2(NUM_BANKS),
  parameter int unsigned TURNAROUND  = 2,
  parameter int unsigned READ_CYCLES = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 req_valid,
  input  logic [SEL_W-1:0]     req_bank,
  output logic                 req_ready,
  output logic [NUM_BANKS-1:0] bank_read_en,
  output logic                 busy,
  output logic                 rd_done,
  output logic                 err_bad_bank,
  output logic [15:0]          read_count,
  output logic [15:0]          switch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_READ = 2'd2
  } state_e;

  // Counter load values: the state exits when the counter has counted down to 0.
  localparam logic [3:0] TURN_LOAD = 4'((TURNAROUND == 0) ? 0 : (TURNAROUND - 1));
  localparam logic [3:0] READ_LOAD = 4'(READ_CYCLES - 1);
  localparam bit         TURN_EN   = (TURNAROUND != 0);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [SEL_W-1:0]     bank_q, bank_d;
  logic [SEL_W-1:0]     last_bank_q, last_bank_d;
  logic                 last_valid_q, last_valid_d;
  logic                 req_ready_q, req_ready_d;
  logic [NUM_BANKS-1:0] en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 rd_done_q, rd_done_d;
  logic                 err_q, err_d;
  logic                 accept_c;
  logic                 bad_bank_c;

  assign accept_c   = req_valid && req_ready_q;
  assign bad_bank_c = 32'(req_bank) >= 32'(NUM_BANKS);

  // State and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      bank_q       <= '0;
      last_bank_q  <= '0;
      last_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
      en_q         <= '0;
      busy_q       <= 1'b0;
      rd_done_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bank_q       <= bank_d;
      last_bank_q  <= last_bank_d;
      last_valid_q <= last_valid_d;
      req_ready_q  <= req_ready_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      rd_done_q    <= rd_done_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bank_d       = bank_q;
    last_bank_d  = last_bank_q;
    last_valid_d = last_valid_q;
    err_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (bad_bank_c) begin
            err_d = 1'b1;
          end else begin
            bank_d = req_bank;
            if ((last_valid_q && (req_bank == last_bank_q)) || !TURN_EN) begin
              state_d = S_READ;
              cnt_d   = READ_LOAD;
            end else begin
              state_d = S_TURN;
              cnt_d   = TURN_LOAD;
            end
          end
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_READ;
          cnt_d   = READ_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_READ: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_IDLE;
          last_bank_d  = bank_q;
          last_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic, evaluated on the next state so the outputs line up with it
  always_comb begin
    en_d        = '0;
    busy_d      = (state_d != S_IDLE);
    req_ready_d = (state_d == S_IDLE);
    rd_done_d   = 1'b0;
    if (state_d == S_READ) begin
      en_d      = NUM_BANKS'(1) << bank_d;
      rd_done_d = (cnt_d == 4'd0);
    end
  end

  assign req_ready    = req_ready_q;
  assign bank_read_en = en_q;
  assign busy         = busy_q;
  assign rd_done      = rd_done_q;
  assign err_bad_bank = err_q;

`ifdef BANK_READ_SEQ_STATS_EN
  logic [15:0] read_count_q;
  logic [15:0] switch_count_q;

  // Saturating counters of completed reads and turnaround entries
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      read_count_q   <= 16'h0000;
      switch_count_q <= 16'h0000;
    end else begin
      if (rd_done_d && (read_count_q != 16'hFFFF)) begin
        read_count_q <= read_count_q + 16'd1;
      end
      if ((state_d == S_TURN) && (state_q != S_TURN) && (switch_count_q != 16'hFFFF)) begin
        switch_count_q <= switch_count_q + 16'd1;
      end
    end
  end

  assign read_count   = read_count_q;
  assign switch_count = switch_count_q;
`else
  assign read_count   = 16'h0000;
  assign switch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bank_read_sequencer.sv
// Scoreboard bench for bank_read_sequencer: DUT A uses default parameters, DUT B uses
// NUM_BANKS=3, TURNAROUND=0, READ_CYCLES=2 for the out-of-range and no-turnaround cases.
module tb_bank_read_sequencer;

  localparam int RC_A = 1;
  localparam int TA_A = 2;
  localparam int RC_B = 2;

`ifdef BANK_READ_SEQ_STATS_EN
  localparam int EXP_RD1 = 4;
  localparam int EXP_SW1 = 3;
  localparam int EXP_RD2 = 1;
  localparam int EXP_SW2 = 1;
`else
  localparam int EXP_RD1 = 0;
  localparam int EXP_SW1 = 0;
  localparam int EXP_RD2 = 0;
  localparam int EXP_SW2 = 0;
`endif

  typedef struct {
    int start;
    int en;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        rst_a, vld_a, rdy_a, busy_a, done_a, err_a;
  logic [1:0]  bank_a;
  logic [3:0]  en_a;
  logic [15:0] rc_a, sc_a;
  logic        rst_b, vld_b, rdy_b, busy_b, done_b, err_b;
  logic [1:0]  bank_b;
  logic [2:0]  en_b;
  logic [15:0] rc_b, sc_b;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [3:0] prev_a = '0;
  logic [2:0] prev_b = '0;
  int run_a = 0;
  int run_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bank_read_sequencer u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst_a), .req_valid(vld_a), .req_bank(bank_a),
    .req_ready(rdy_a), .bank_read_en(en_a), .busy(busy_a), .rd_done(done_a),
    .err_bad_bank(err_a), .read_count(rc_a), .switch_count(sc_a)
  );

  bank_read_sequencer #(
    .NUM_BANKS(3), .TURNAROUND(0), .READ_CYCLES(2)
  ) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst_b), .req_valid(vld_b), .req_bank(bank_b),
    .req_ready(rdy_b), .bank_read_en(en_b), .busy(busy_b), .rd_done(done_b),
    .err_bad_bank(err_b), .read_count(rc_b), .switch_count(sc_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, exp);
    end
  endtask

  // Issue one request to DUT A; lat is the hand-computed delay of the read start.
  task automatic req_a(input logic [1:0] bank, input int lat, input bit push);
    bit ok = 1'b0;
    int a = 0;
    vld_a  = 1'b1;
    bank_a = bank;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = rdy_a;
      a  = cyc + 1;
      @(posedge clk);
      #1;
    end
    vld_a  = 1'b0;
    bank_a = 2'd0;
    chk("accept_a", int'(ok), 1);
    if (ok && push) qa.push_back('{start: a + lat, en: 1 << bank, err: 1'b0});
  endtask

  task automatic req_b(input logic [1:0] bank, input bit push, input bit err);
    bit ok = 1'b0;
    int a = 0;
    vld_b  = 1'b1;
    bank_b = bank;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = rdy_b;
      a  = cyc + 1;
      @(posedge clk);
      #1;
    end
    vld_b  = 1'b0;
    bank_b = 2'd0;
    chk("accept_b", int'(ok), 1);
    if (ok && push) qb.push_back('{start: a, en: err ? 0 : (1 << bank), err: err});
  endtask

  // Monitor A: one-hot every cycle, pop on read start or error pulse
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("onehot_a", int'($countones(en_a) <= 1), 1);
      if (en_a != '0) run_a = (prev_a != '0) ? run_a + 1 : 1;
      if (en_a != '0 && prev_a == '0) begin
        if (qa.size() == 0) chk("unexpected_read_a", int'(en_a), 0);
        else begin
          ea = qa.pop_front();
          chk("read_kind_a", int'(ea.err), 0);
          chk("read_bank_a", int'(en_a), ea.en);
          chk("read_start_a", cyc, ea.start);
        end
      end
      if (done_a) begin
        chk("rd_done_en_a", int'(en_a != '0), 1);
        chk("rd_done_len_a", run_a, RC_A);
      end
      if (err_a) begin
        if (qa.size() == 0) chk("unexpected_err_a", int'(err_a), 0);
        else begin
          ea = qa.pop_front();
          chk("err_kind_a", int'(ea.err), 1);
          chk("err_start_a", cyc, ea.start);
        end
      end
      prev_a = en_a;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("onehot_b", int'($countones(en_b) <= 1), 1);
      if (en_b != '0) run_b = (prev_b != '0) ? run_b + 1 : 1;
      if (en_b != '0 && prev_b == '0) begin
        if (qb.size() == 0) chk("unexpected_read_b", int'(en_b), 0);
        else begin
          eb = qb.pop_front();
          chk("read_kind_b", int'(eb.err), 0);
          chk("read_bank_b", int'(en_b), eb.en);
          chk("read_start_b", cyc, eb.start);
        end
      end
      if (done_b) begin
        chk("rd_done_en_b", int'(en_b != '0), 1);
        chk("rd_done_len_b", run_b, RC_B);
      end
      if (err_b) begin
        if (qb.size() == 0) chk("unexpected_err_b", int'(err_b), 0);
        else begin
          eb = qb.pop_front();
          chk("err_kind_b", int'(eb.err), 1);
          chk("err_start_b", cyc, eb.start);
          chk("err_en_b", int'(en_b), 0);
        end
      end
      prev_b = en_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; vld_a = 1'b0; bank_a = 2'd0;
    rst_b = 1'b1; vld_b = 1'b0; bank_b = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_a", int'(rdy_a), 0);
    chk("rst_en_a", int'(en_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_err_a", int'(err_a), 0);
    chk("rst_rc_a", int'(rc_a), 0);
    chk("rst_sc_a", int'(sc_a), 0);
    chk("rst_ready_b", int'(rdy_b), 0);
    chk("rst_en_b", int'(en_b), 0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // First access takes the turnaround path; repeat to same bank does not
    req_a(2'd2, TA_A, 1'b1);
    @(negedge clk);
    chk("busy_t1_a", int'(busy_a), 1);
    chk("en_t1_a", int'(en_a), 0);
    req_a(2'd2, 0, 1'b1);
    req_a(2'd0, TA_A, 1'b1);
    req_a(2'd1, TA_A, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("read_count_a", int'(rc_a), EXP_RD1);
    chk("switch_count_a", int'(sc_a), EXP_SW1);

    // Reset during turnaround: no read, counters and last bank cleared
    req_a(2'd3, TA_A, 1'b0);
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_en_a", int'(en_a), 0);
    chk("abort_busy_a", int'(busy_a), 0);
    chk("abort_done_a", int'(done_a), 0);
    chk("abort_rc_a", int'(rc_a), 0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    req_a(2'd1, TA_A, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("read_count2_a", int'(rc_a), EXP_RD2);
    chk("switch_count2_a", int'(sc_a), EXP_SW2);

    // DUT B: no turnaround, 2-cycle reads, bank 3 out of range
    req_b(2'd1, 1'b1, 1'b0);
    req_b(2'd2, 1'b1, 1'b0);
    req_b(2'd1, 1'b1, 1'b0);
    req_b(2'd3, 1'b1, 1'b1);
    @(negedge clk);
    chk("ready_after_err_b", int'(rdy_b), 1);
    chk("en_after_err_b", int'(en_b), 0);
    req_b(2'd0, 1'b1, 1'b0);
    req_b(2'd2, 1'b1, 1'b0);
    rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_en_b", int'(en_b), 0);
    chk("abort_done_b", int'(done_b), 0);
    chk("abort_busy_b", int'(busy_b), 0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    req_b(2'd1, 1'b1, 1'b0);

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("queue_empty_a", qa.size(), 0);
    chk("queue_empty_b", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
